// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU byte writes are queued in a small FIFO
// and shifted out LSB first; a status word is readable at the same I/O address.
module uart_tx_mmio #(
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int BAUD          = 115200,
    parameter int FIFO_DEPTH    = 8,
    parameter int IO_CTRL_BIT   = 22,
    parameter int UART_CTRL_BIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_rstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    output logic        uart_tx_o
);
    // DIV must be at least 2 so the baud counter has a reload value of at least 1.
    localparam int DIV     = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W   = $clog2(DIV);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_F_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   DIV_M1    = CNT_W'(DIV - 1);
    localparam logic [CNT_F_W-1:0] DEPTH_CNT = CNT_F_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    function automatic logic [3:0] sat_count(input logic [CNT_F_W-1:0] c);
        if (32'(c) > 32'd15) begin
            return 4'hF;
        end
        return 4'(c);
    endfunction

    logic                 sel;
    logic                 push_req;
    logic                 rd_req;
    logic                 push_ok;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 busy;
    logic [31:0]          status;
    logic                 line_bit;
    logic                 unused_bits;

    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_F_W-1:0]   fifo_cnt;
    logic                 overflow;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 tx_q;
    logic [31:0]          rdata_q;

    assign sel      = mem_addr_i[IO_CTRL_BIT] & mem_addr_i[UART_CTRL_BIT];
    assign push_req = sel & mem_wmask_i[0];
    assign rd_req   = sel & mem_rstrb_i;

    assign unused_bits = ^{mem_addr_i, mem_wmask_i[3:1], mem_wdata_i[31:8]};

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_CNT);

    // A pop happens from IDLE, or at the last cycle of a stop bit so frames run back to back.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && (baud_cnt == '0)));

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign push_ok = push_req && (!fifo_full || pop);

    assign busy = !fifo_empty || (state != IDLE);

    always_comb begin
        status      = '0;
        status[0]   = busy;
        status[1]   = fifo_full;
        status[2]   = overflow;
        status[7:4] = sat_count(fifo_cnt);
    end

    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift[0];
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= mem_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_F_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_F_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            // A dropped push on the same edge as a status read keeps the flag set.
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (rd_req) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rd_req ? status : 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop) begin
            shift <= fifo_mem[rd_ptr];
        end else if ((state == DATA) && (baud_cnt == '0)) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_q <= line_bit;
            case (state)
                IDLE: begin
                    if (pop) begin
                        baud_cnt <= DIV_M1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_M1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_M1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == '0) begin
                        if (pop) begin
                            baud_cnt <= DIV_M1;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uart_tx_o   = tx_q;
    assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed and random bus traffic against a queue-based
// reference model plus a mid-bit sampling serial receiver.
module tb_uart_tx_mmio;
    localparam int DIV   = 10;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * DIV;
    localparam logic [31:0] UART_ADDR = 32'h0040_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0;
    logic        rstrb = 1'b0;
    logic [31:0] rdata;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic        tx;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .CLK_FREQ_HZ  (1000),
        .BAUD         (100),
        .FIFO_DEPTH   (DEPTH),
        .IO_CTRL_BIT  (22),
        .UART_CTRL_BIT(4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .mem_addr_i (addr),
        .mem_rstrb_i(rstrb),
        .mem_rdata_o(rdata),
        .mem_wmask_i(wmask),
        .mem_wdata_i(wdata),
        .uart_tx_o  (tx)
    );

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model: pending bytes, the frame currently on the line, sticky overflow.
    logic [7:0]  mq[$];
    bit          in_frame = 0;
    int          fr_pop = 0;
    logic [7:0]  fr_byte = '0;
    bit          m_ovf = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_line = 1'b1;
    logic [7:0]  exp_tx[$];

    // Serial receiver state.
    bit          rx_act = 0;
    int          rx_t0 = 0;
    logic [7:0]  rx_sh = '0;
    int          rx_q[$];
    int          rx_t[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic        sel, push, rd, set_ovf;
        logic [31:0] st;
        int          n, k;
        if (!rst_n) begin
            mq.delete();
            exp_tx.delete();
            in_frame  = 0;
            m_ovf     = 0;
            exp_rdata = '0;
            exp_line  = 1'b1;
            return;
        end
        sel  = addr[22] & addr[4];
        push = sel & wmask[0];
        rd   = sel & rstrb;
        n    = mq.size();
        st      = '0;
        st[0]   = (n != 0) || in_frame;
        st[1]   = (n == DEPTH);
        st[2]   = m_ovf;
        st[7:4] = (n > 15) ? 4'hF : 4'(n);
        exp_rdata = rd ? st : 32'h0;
        if (in_frame && edge_n == fr_pop + FRAME) in_frame = 0;
        if (!in_frame && n != 0) begin
            fr_byte  = mq.pop_front();
            fr_pop   = edge_n;
            in_frame = 1;
            exp_tx.push_back(fr_byte);
        end
        set_ovf = 0;
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
            else set_ovf = 1;
        end
        if (set_ovf) m_ovf = 1;
        else if (rd) m_ovf = 0;
        exp_line = 1'b1;
        if (in_frame && edge_n > fr_pop && edge_n <= fr_pop + FRAME) begin
            k = (edge_n - fr_pop - 1) / DIV;
            if (k == 0) exp_line = 1'b0;
            else if (k <= 8) exp_line = fr_byte[k-1];
        end
    endtask

    task automatic rx_step();
        int d, k;
        if (!rst_n) begin
            rx_act = 0;
            rx_q.delete();
            rx_t.delete();
            return;
        end
        if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act = 1;
                rx_t0  = edge_n;
            end
        end else begin
            d = edge_n - rx_t0;
            if (d % DIV == DIV / 2) begin
                k = d / DIV;
                if (k >= 1 && k <= 8) rx_sh[k-1] = tx;
                else if (k == 9) begin
                    rx_q.push_back(int'({tx, rx_sh}));
                    rx_t.push_back(rx_t0);
                    rx_act = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_step();
        @(negedge clk);
        check("line", {31'b0, tx}, {31'b0, exp_line});
        check("rdata", rdata, exp_rdata);
        rx_step();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        tick();
        wmask = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        addr  = a;
        rstrb = 1'b1;
        tick();
        rstrb = 1'b0;
        v = rdata;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((in_frame || mq.size() != 0 || rx_act) && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_drain_bound"}, 32'(n < 5000), 32'd1);
        repeat (5) tick();
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rx_t.delete();
        exp_tx.delete();
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] a;
        int w0, r, nb;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        bus_read(UART_ADDR, st);
        check("reset_status", st, 32'h0);

        // Single byte 0x55
        clear_logs();
        w0 = edge_n + 1;
        bus_write(UART_ADDR, 32'h55, 4'b0001);
        tick();
        check("single_pre_start", {31'b0, tx}, 32'd1);
        tick();
        check("single_start_bit", {31'b0, tx}, 32'd0);
        repeat (20) tick();
        bus_read(UART_ADDR, st);
        check("single_busy", {31'b0, st[0]}, 32'd1);
        drain("single");
        bus_read(UART_ADDR, st);
        check("single_idle_status", st, 32'h0);
        check("single_count", rx_q.size(), 32'd1);
        if (rx_q.size() >= 1) begin
            check("single_byte", rx_q[0], 32'h155);
            check("single_latency", rx_t[0] - w0, 32'd2);
        end

        // Back-to-back frames
        clear_logs();
        w0 = edge_n + 1;
        bus_write(UART_ADDR, 32'h41, 4'b0001);
        bus_write(UART_ADDR, 32'h42, 4'b0001);
        bus_write(UART_ADDR, 32'h43, 4'b0001);
        drain("b2b");
        check("b2b_count", rx_q.size(), 32'd3);
        if (rx_q.size() >= 3) begin
            check("b2b_byte0", rx_q[0], 32'h141);
            check("b2b_byte1", rx_q[1], 32'h142);
            check("b2b_byte2", rx_q[2], 32'h143);
            check("b2b_latency", rx_t[0] - w0, 32'd2);
            check("b2b_gap01", rx_t[1] - rx_t[0], 32'(FRAME));
            check("b2b_gap12", rx_t[2] - rx_t[1], 32'(FRAME));
        end

        // Overflow
        clear_logs();
        for (int i = 0; i < 10; i++) bus_write(UART_ADDR, 32'(i), 4'b0001);
        bus_read(UART_ADDR, st);
        check("ovf_read1", st, 32'h87);
        bus_read(UART_ADDR, st);
        check("ovf_read2", st, 32'h83);
        drain("ovf");
        check("ovf_count", rx_q.size(), 32'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++) check("ovf_byte", rx_q[i], 32'h100 | 32'(i));

        // Address / mask decode
        clear_logs();
        bus_write(UART_ADDR, 32'h5A, 4'b1110);
        bus_write(UART_ADDR & ~32'h10, 32'h5A, 4'b0001);
        bus_write(UART_ADDR & ~32'h0040_0000, 32'h5A, 4'b0001);
        repeat (150) tick();
        check("decode_no_frame", rx_q.size(), 32'd0);
        bus_read(UART_ADDR, st);
        check("decode_status", st, 32'h0);

        // Random traffic
        clear_logs();
        for (int c = 0; c < 2500; c++) begin
            r = $urandom_range(0, 99);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a | UART_ADDR;
            if (r < 3) begin
                nb = $urandom_range(1, 10);
                for (int j = 0; j < nb; j++) bus_write(UART_ADDR, $urandom, 4'b0001);
            end else if (r < 7) begin
                bus_write(a, $urandom, 4'($urandom_range(0, 15)));
            end else if (r < 11) begin
                bus_read(a, st);
            end else begin
                tick();
            end
        end
        drain("rand");
        check("rand_count", rx_q.size(), exp_tx.size());
        for (int i = 0; i < rx_q.size() && i < exp_tx.size(); i++)
            check("rand_byte", rx_q[i], 32'h100 | 32'(exp_tx[i]));

        // Reset in the middle of a frame with two bytes still queued
        clear_logs();
        bus_write(UART_ADDR, 32'hA5, 4'b0001);
        bus_write(UART_ADDR, 32'h3C, 4'b0001);
        bus_write(UART_ADDR, 32'hF0, 4'b0001);
        repeat (45) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_tx", {31'b0, tx}, 32'd1);
        check("midreset_rdata", rdata, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (300) tick();
        check("midreset_no_traffic", rx_q.size(), 32'd0);
        bus_read(UART_ADDR, st);
        check("midreset_status", st, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
